// File: rtl/monitor_contador_pkg.sv
// Shared types and error codes for the 2-bit counter monitor.
package monitor_contador_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } mon_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEQ  = 2'b01;
  localparam logic [1:0] ERR_EN   = 2'b10;

endpackage

// File: rtl/monitor_contador_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/monitor_contador.sv
// Passive legality checker for the 2-bit counter: tracks the expected state,
// flags sequence mismatches and over-wide enables, counts errors and wraps.
module monitor_contador
  import monitor_contador_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
) (
  input  logic                  clck_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  hold_i,
  input  logic [WIDTH-1:0]      state_i,
  input  logic                  clear_i,
  output logic                  synced_o,
  output logic                  error_o,
  output logic [1:0]            error_code_o,
  output logic                  fault_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic [WRAP_CNT_W-1:0] wrap_count_o
);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] ref_val_q, ref_val_d;
  logic             step_pending_q, step_pending_d;
  logic             enable_dly_q, enable_dly_d;
  logic             error_q, error_d;
  logic [1:0]       code_q, code_d;
  logic             err_inc, wrap_inc;

  logic             check_en;
  logic [WIDTH-1:0] expect_val;
  logic             seq_err, en_err;

  // The counter registers its step on the same edge we see the tick, so the
  // value one cycle later must be ref+1 only when that tick was a real step.
  assign check_en   = (state_q != UNSYNC);
  assign expect_val = step_pending_q ? (ref_val_q + WIDTH'(1)) : ref_val_q;
  assign seq_err    = check_en && (state_i != expect_val);
  assign en_err     = check_en && enable_i && enable_dly_q;

  always_comb begin
    state_d        = state_q;
    ref_val_d      = state_i;
    step_pending_d = enable_i && !hold_i;
    enable_dly_d   = enable_i;
    error_d        = 1'b0;
    code_d         = ERR_NONE;
    err_inc        = 1'b0;
    wrap_inc       = 1'b0;

    if (clear_i) begin
      state_d        = UNSYNC;
      step_pending_d = 1'b0;
      enable_dly_d   = 1'b0;
    end else begin
      case (state_q)
        UNSYNC: state_d = TRACK;
        TRACK, FAULT: begin
          if (seq_err || en_err) begin
            error_d = 1'b1;
            code_d  = (seq_err ? ERR_SEQ : ERR_NONE) | (en_err ? ERR_EN : ERR_NONE);
            err_inc = 1'b1;
            state_d = FAULT;
          end
          // A mismatch landing on zero is not a wrap.
          wrap_inc = step_pending_q && !seq_err &&
                     (ref_val_q == '1) && (state_i == '0);
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clck_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= UNSYNC;
      ref_val_q      <= '0;
      step_pending_q <= 1'b0;
      enable_dly_q   <= 1'b0;
      error_q        <= 1'b0;
      code_q         <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      ref_val_q      <= ref_val_d;
      step_pending_q <= step_pending_d;
      enable_dly_q   <= enable_dly_d;
      error_q        <= error_d;
      code_q         <= code_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk     (clck_i),
    .rst_n   (rst_i),
    .clr     (clear_i),
    .inc     (err_inc),
    .count_o (err_count_o)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk     (clck_i),
    .rst_n   (rst_i),
    .clr     (clear_i),
    .inc     (wrap_inc),
    .count_o (wrap_count_o)
  );

  assign synced_o     = (state_q != UNSYNC);
  assign fault_o      = (state_q == FAULT);
  assign error_o      = error_q;
  assign error_code_o = code_q;

endmodule

// File: tb/tb_monitor_contador.sv
// Directed bench for monitor_contador with hand-computed expectations.
module tb_monitor_contador;

  logic        clck_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        hold_i = 1'b0;
  logic [1:0]  state_i = 2'd0;
  logic        clear_i = 1'b0;
  logic        synced_o;
  logic        error_o;
  logic [1:0]  error_code_o;
  logic        fault_o;
  logic [7:0]  err_count_o;
  logic [15:0] wrap_count_o;

  int checks = 0;
  int failures = 0;
  logic [1:0] cnt = 2'd0;
  logic err_seen = 1'b0;

  monitor_contador #(.WIDTH(2), .ERR_CNT_W(8), .WRAP_CNT_W(16)) dut (
    .clck_i       (clck_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .hold_i       (hold_i),
    .state_i      (state_i),
    .clear_i      (clear_i),
    .synced_o     (synced_o),
    .error_o      (error_o),
    .error_code_o (error_code_o),
    .fault_o      (fault_o),
    .err_count_o  (err_count_o),
    .wrap_count_o (wrap_count_o)
  );

  always #5 clck_i = ~clck_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock with explicit inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic en, input logic hl, input logic [1:0] st);
    enable_i = en;
    hold_i   = hl;
    state_i  = st;
    clear_i  = 1'b0;
    @(posedge clck_i);
    #1;
    err_seen = err_seen | error_o;
  endtask

  // One clock driven by a conforming counter model.
  task automatic step(input logic en, input logic hl);
    cyc(en, hl, cnt);
    if (en && !hl) cnt = cnt + 2'd1;
  endtask

  task automatic tick();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_clear(input logic [1:0] st);
    enable_i = 1'b0;
    hold_i   = 1'b0;
    state_i  = st;
    clear_i  = 1'b1;
    @(posedge clck_i);
    #1;
    clear_i  = 1'b0;
  endtask

  initial begin
    logic [15:0] wrap_before;

    // Reset state
    repeat (3) @(posedge clck_i);
    #1;
    chk("rst_synced", synced_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_errcnt", err_count_o, 0);
    chk("rst_wrap", wrap_count_o, 0);
    rst_i = 1'b1;

    step(1'b0, 1'b0);
    chk("sync_after_rst", synced_o, 1);

    // Eight conforming ticks: 0,1,2,3,0,1,2,3,0
    err_seen = 1'b0;
    repeat (8) tick();
    chk("ticks_wrap", wrap_count_o, 2);
    chk("ticks_errcnt", err_count_o, 0);
    chk("ticks_no_err", err_seen, 0);

    // Hold with state frozen at 2
    repeat (2) tick();
    chk("hold_pre_state", cnt, 2);
    repeat (5) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    chk("hold_no_err", err_seen, 0);
    chk("hold_wrap", wrap_count_o, 2);
    chk("hold_fault", fault_o, 0);

    // Bring counter to 1 (passes through a wrap), then jump 1 -> 3
    repeat (3) tick();
    chk("pre_jump_wrap", wrap_count_o, 3);
    cyc(1'b1, 1'b0, 2'd1);
    chk("jump_no_err_yet", error_o, 0);
    cyc(1'b0, 1'b0, 2'd3);
    chk("jump_error", error_o, 1);
    chk("jump_code", error_code_o, 2'b01);
    chk("jump_fault", fault_o, 1);
    chk("jump_errcnt", err_count_o, 1);
    cyc(1'b0, 1'b0, 2'd3);
    chk("jump_pulse_end", error_o, 0);
    chk("jump_fault_sticky", fault_o, 1);
    cnt = 2'd3;
    err_seen = 1'b0;
    tick();
    chk("post_jump_wrap", wrap_count_o, 4);
    chk("post_jump_no_err", err_seen, 0);
    chk("post_jump_errcnt", err_count_o, 1);

    // Clear from FAULT, then resync
    do_clear(cnt);
    chk("clr1_synced", synced_o, 0);
    chk("clr1_fault", fault_o, 0);
    chk("clr1_errcnt", err_count_o, 0);
    chk("clr1_wrap", wrap_count_o, 0);
    step(1'b0, 1'b0);
    chk("clr1_resync", synced_o, 1);

    // Two-cycle enable while counter steps 0->1->2
    step(1'b1, 1'b0);
    chk("wide_first_ok", error_o, 0);
    step(1'b1, 1'b0);
    chk("wide_error", error_o, 1);
    chk("wide_code", error_code_o, 2'b10);
    step(1'b0, 1'b0);
    chk("wide_single_pulse", error_o, 0);
    chk("wide_errcnt", err_count_o, 1);

    // Mismatch plus wide enable in the same cycle: expected 3, got 0
    cyc(1'b1, 1'b0, 2'd2);
    cyc(1'b1, 1'b0, 2'd0);
    chk("both_code", error_code_o, 2'b11);
    chk("both_errcnt", err_count_o, 2);
    cyc(1'b0, 1'b0, 2'd1);
    chk("both_recover", error_o, 0);
    cnt = 2'd1;

    // Mismatch landing on 0 from ref 3 is not a wrap
    repeat (2) tick();
    wrap_before = wrap_count_o;
    cyc(1'b0, 1'b0, 2'd0);
    chk("false_wrap_err", error_code_o, 2'b01);
    chk("false_wrap_cnt", wrap_count_o, wrap_before);
    chk("false_wrap_errcnt", err_count_o, 3);

    // 300 back-to-back mismatches saturate the error counter
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, (i % 2 == 0) ? 2'd2 : 2'd0);
    chk("sat_errcnt", err_count_o, 255);
    chk("sat_fault", fault_o, 1);

    // Clear in FAULT with mismatching inputs: no error during clear or resync
    do_clear(2'd1);
    chk("clr2_error", error_o, 0);
    chk("clr2_synced", synced_o, 0);
    chk("clr2_errcnt", err_count_o, 0);
    chk("clr2_fault", fault_o, 0);
    cyc(1'b0, 1'b0, 2'd3);
    chk("clr2_resync_err", error_o, 0);
    chk("clr2_resync_sync", synced_o, 1);
    cyc(1'b0, 1'b0, 2'd3);
    chk("clr2_track_ok", error_o, 0);
    cnt = 2'd3;
    tick();
    chk("clr2_wrap", wrap_count_o, 1);
    cyc(1'b0, 1'b0, 2'd2);
    chk("pre_rst_error", error_o, 1);
    chk("pre_rst_fault", fault_o, 1);

    // Asynchronous reset mid-cycle
    #3 rst_i = 1'b0;
    #1;
    chk("arst_synced", synced_o, 0);
    chk("arst_error", error_o, 0);
    chk("arst_code", error_code_o, 0);
    chk("arst_fault", fault_o, 0);
    chk("arst_errcnt", err_count_o, 0);
    chk("arst_wrap", wrap_count_o, 0);
    @(posedge clck_i);
    #1 rst_i = 1'b1;
    cyc(1'b0, 1'b0, 2'd2);
    chk("post_rst_no_err", error_o, 0);
    chk("post_rst_synced", synced_o, 1);
    cyc(1'b1, 1'b0, 2'd2);
    cyc(1'b0, 1'b0, 2'd3);
    chk("post_rst_step_ok", error_o, 0);
    chk("post_rst_fault", fault_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
